// File: rtl/feeder_pkg.sv
// Shared types and sizing helpers for the operand feeder and its FIFO.
package feeder_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 8;
  localparam int unsigned GAP_DEF    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } feeder_state_e;

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: one extra bit so the count can reach DEPTH.
  function automatic int unsigned lvl_w(input int unsigned depth);
    return ptr_w(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-array FIFO with an occupancy counter; head word is read combinationally.
module sync_fifo
  import feeder_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic [DATA_W-1:0]         wdata_i,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [lvl_w(DEPTH)-1:0]   level_o
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned LVL_W = lvl_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (count_q == LVL_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + LVL_W'(1);
      2'b01:   count_d = count_q - LVL_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/operand_feeder.sv
// Buffers operands and issues them as paced one-cycle enable pulses to the accumulator.
module operand_feeder
  import feeder_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned GAP    = GAP_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      in_ready,
  output logic                      enable,
  output logic [DATA_W-1:0]         value,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic [15:0]               issued
);

  localparam int unsigned HOLD_W = (GAP > 1) ? $clog2(GAP) : 1;

  feeder_state_e     state_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              enable_q;
  logic [DATA_W-1:0] value_q;
  logic [15:0]       issued_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_head;

  assign in_ready = !fifo_full;
  assign enable   = enable_q;
  assign value    = value_q;
  assign issued   = issued_q;

  // A pop is only requested when idle or on the final hold cycle.
  always_comb begin
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: fifo_pop = !fifo_empty;
      ST_HOLD: fifo_pop = (hold_cnt_q == '0) && !fifo_empty;
      default: fifo_pop = 1'b0;
    endcase
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (in_valid),
    .pop_i   (fifo_pop),
    .wdata_i (in_data),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      enable_q   <= 1'b0;
      value_q    <= '0;
      issued_q   <= '0;
    end else if (fifo_pop) begin
      value_q  <= fifo_head;
      enable_q <= 1'b1;
      issued_q <= issued_q + 16'd1;
      state_q  <= ST_ISSUE;
    end else begin
      enable_q <= 1'b0;
      case (state_q)
        ST_ISSUE: begin
          // Hold spans GAP-1 cycles so the next pulse lands GAP cycles later.
          hold_cnt_q <= HOLD_W'(GAP - 2);
          state_q    <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt_q == '0) state_q <= ST_IDLE;
          else                  hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_feeder.sv
// Randomized bench for operand_feeder against a queue-based pacing model.
module tb_operand_feeder;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int GAP    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              enable;
  logic [DATA_W-1:0] value;
  logic [3:0]        level;
  logic [15:0]       issued;

  always #5 clk = ~clk;

  operand_feeder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .GAP(GAP)) dut (
    .CLK      (clk),
    .RST      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .enable   (enable),
    .value    (value),
    .level    (level),
    .issued   (issued)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    else
      n_pass++;
  endtask

  // Model: FIFO queue; a pulse fires at any edge where the queue is non-empty
  // and at least GAP edges have passed since the previous pulse.
  logic [DATA_W-1:0] mq[$];
  int                edge_n     = 0;
  int                last_pulse = -1000;
  bit                m_en       = 1'b0;
  logic [DATA_W-1:0] m_val      = '0;
  logic [15:0]       m_iss      = '0;
  bit                started    = 1'b0;

  always @(posedge clk) begin : model
    bit do_push;
    bit do_pop;
    edge_n++;
    if (rst) begin
      mq.delete();
      last_pulse = -1000;
      m_en       = 1'b0;
      m_val      = '0;
      m_iss      = '0;
      started    = 1'b1;
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = (mq.size() > 0) && (edge_n - last_pulse >= GAP);
      m_en    = do_pop;
      if (do_pop) begin
        m_val      = mq.pop_front();
        m_iss      = m_iss + 16'd1;
        last_pulse = edge_n;
      end
      if (do_push) mq.push_back(in_data);
    end
  end

  int                acc = 0;
  int                pulse_cyc[$];
  logic [DATA_W-1:0] pulse_val[$];

  always @(negedge clk) begin
    cyc++;
    if (started) begin
      chk("enable",   64'(enable),   64'(m_en));
      chk("value",    64'(value),    64'(m_val));
      chk("level",    64'(level),    64'(mq.size()));
      chk("issued",   64'(issued),   64'(m_iss));
      chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
      if (enable) begin
        acc += int'(value);
        pulse_cyc.push_back(cyc);
        pulse_val.push_back(value);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit hit;
    bit prev_en;
    int rate;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    step();
    chk("rst_enable", 64'(enable), 64'd0);
    chk("rst_value",  64'(value),  64'd0);
    chk("rst_level",  64'(level),  64'd0);
    chk("rst_issued", 64'(issued), 64'd0);
    chk("rst_ready",  64'(in_ready), 64'd1);
    rst = 1'b0;

    // Single word: one edge to enter the FIFO, next edge pulses it out.
    in_valid = 1'b1; in_data = 32'h10;
    step();
    in_valid = 1'b0;
    chk("t1_level_after_push", 64'(level),  64'd1);
    chk("t1_no_bypass",        64'(enable), 64'd0);
    step();
    chk("t1_enable", 64'(enable), 64'd1);
    chk("t1_value",  64'(value),  64'h10);
    chk("t1_issued", 64'(issued), 64'd1);
    chk("t1_level",  64'(level),  64'd0);

    // Back-to-back 1,2,3: pulses GAP apart, accumulator total 6.
    idle(6);
    acc = 0; pulse_cyc.delete(); pulse_val.delete();
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = DATA_W'(i);
      step();
    end
    idle(15);
    chk("t2_npulses", 64'(pulse_cyc.size()), 64'd3);
    if (pulse_cyc.size() >= 3) begin
      chk("t2_gap01", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'(GAP));
      chk("t2_gap12", 64'(pulse_cyc[2] - pulse_cyc[1]), 64'(GAP));
      chk("t2_val0", 64'(pulse_val[0]), 64'd1);
      chk("t2_val1", 64'(pulse_val[1]), 64'd2);
      chk("t2_val2", 64'(pulse_val[2]), 64'd3);
    end
    chk("t2_acc_total", 64'(acc), 64'd6);

    // Fill to DEPTH, offer extra words while full, then drain.
    hit = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && !hit; i++) begin
      in_data = 32'h100 + DATA_W'(i);
      step();
      if (level == 4'(DEPTH)) hit = 1'b1;
    end
    chk("t3_full_reached", 64'(hit), 64'd1);
    chk("t3_ready_low",    64'(in_ready), 64'd0);
    for (int i = 0; i < 2; i++) begin
      in_data = 32'hBAD0 + DATA_W'(i);
      step();
    end
    in_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (in_ready) hit = 1'b1;
      else step();
    end
    chk("t3_ready_back",   64'(hit),   64'd1);
    chk("t3_level_on_ready", 64'(level), 64'(DEPTH - 1));
    idle(30);

    // Reset while holding with 4 queued words.
    hit = 1'b0; prev_en = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 30 && !hit; i++) begin
      in_data = 32'h400 + DATA_W'(i);
      step();
      if (level == 4'd4 && !enable && prev_en) hit = 1'b1;
      prev_en = enable;
    end
    chk("t4_hold_l4_reached", 64'(hit), 64'd1);
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("t4_enable", 64'(enable), 64'd0);
    chk("t4_value",  64'(value),  64'd0);
    chk("t4_level",  64'(level),  64'd0);
    chk("t4_issued", 64'(issued), 64'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t4_quiet", 64'(enable), 64'd0);
    end

    // Random traffic at several offered rates; many pointer wraps.
    for (int ph = 0; ph < 4; ph++) begin
      rate = (ph == 0) ? 30 : (ph == 1) ? 60 : (ph == 2) ? 90 : 100;
      for (int i = 0; i < 200; i++) begin
        in_valid = ($urandom_range(99) < rate);
        in_data  = $urandom;
        step();
      end
    end
    idle(40);

    // Counter wrap: preload near the top, then three more pulses.
    @(posedge clk);
    #2;
    force dut.issued_q = 16'hFFFE;
    release dut.issued_q;
    m_iss = 16'hFFFE;
    step();
    chk("t6_preload", 64'(issued), 64'hFFFE);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hA0 + DATA_W'(i);
      step();
    end
    idle(15);
    chk("t6_wrap", 64'(issued), 64'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
